// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory, big-endian,
// holding the CPU while loading. Optional running word sum: define IMEM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start; bad requests pulse error
// ACCEPT | s_ready high, waiting for the next word
// WRITE  | four byte writes of the current word, idx 0..3
// FINISH | last word written; done pulses on the way back to IDLE
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [31:0] TOP_ADDR  = 32'(MEM_BYTES - 1);
  localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / 4);

  state_t           state;
  logic [31:0]      cur_addr;
  logic [CNT_W-1:0] words_left;
  logic [31:0]      shift;
  logic [1:0]       idx;
  logic             bad_req;
  logic [31:0]      next_addr;

  always_comb begin
    bad_req = (base_addr[1:0] != 2'b00) || (base_addr >= 32'(MEM_BYTES))
              || (32'(word_count) > MAX_WORDS);
    next_addr = (cur_addr == TOP_ADDR) ? 32'd0 : cur_addr + 32'd1;
  end

  assign s_ready  = (state == S_ACCEPT);
  assign busy     = (state != S_IDLE);
  assign cpu_hold = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      words_left <= '0;
      shift      <= '0;
      idx        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (bad_req) begin
              error <= 1'b1;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              checksum <= '0;
`endif
              if (word_count == '0) begin
                state <= S_FINISH;
              end else begin
                cur_addr   <= base_addr;
                words_left <= word_count;
                state      <= S_ACCEPT;
              end
            end
          end
        end
        S_ACCEPT: begin
          // byte 0 goes out straight from s_data so the write lands in the first WRITE cycle
          if (s_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= cur_addr;
            mem_wdata <= s_data[31:24];
            shift     <= {s_data[23:0], 8'h00};
            cur_addr  <= next_addr;
            idx       <= 2'd0;
            state     <= S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum  <= checksum + s_data;
`endif
          end
        end
        S_WRITE: begin
          if (idx == 2'd3) begin
            words_left <= words_left - CNT_W'(1);
            state      <= (words_left == CNT_W'(1)) ? S_FINISH : S_ACCEPT;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= cur_addr;
            mem_wdata <= shift[31:24];
            shift     <= {shift[23:0], 8'h00};
            cur_addr  <= next_addr;
            idx       <= idx + 2'd1;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
